// File: rtl/cond_flags_reg.sv
// Architectural condition-code register {N,V,C,Z} with a one-entry pending
// stage, stall/flush handling and a single shadow copy for save/restore.
module cond_flags_reg #(
   parameter int DATA_W    = 32,
   parameter int COND_BITS = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 alu_valid,
   input  logic                 alu_set_flags,
   input  logic [1:0]           alu_op_class,
   input  logic [DATA_W-1:0]    alu_a,
   input  logic [DATA_W-1:0]    alu_b,
   input  logic [DATA_W-1:0]    alu_result,
   input  logic                 alu_carry_out,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 save,
   input  logic                 restore,
   output logic [COND_BITS-1:0] cond_code,
   output logic                 flags_busy
);

   if (COND_BITS != 4) begin : g_bad_cond_bits
      $error("cond_flags_reg supports COND_BITS == 4 only");
   end

   typedef enum logic {EMPTY, PENDING} state_t;

   localparam logic [1:0] CLS_LOGIC = 2'b00;
   localparam logic [1:0] CLS_ADD   = 2'b01;
   localparam logic [1:0] CLS_SUB   = 2'b10;
   localparam logic [1:0] CLS_RSVD  = 2'b11;

   localparam int N_BIT = 3;
   localparam int V_BIT = 2;
   localparam int C_BIT = 1;
   localparam int Z_BIT = 0;

   state_t                 state_q, state_d;
   logic [COND_BITS-1:0]   pend_q, pend_d;
   logic [COND_BITS-1:0]   cond_q, cond_d;
   logic [COND_BITS-1:0]   shadow_q, shadow_d;

   logic                   a_msb, b_msb, r_msb;
   logic                   cur_c, cur_v;
   logic                   cand_c, cand_v;
   logic [COND_BITS-1:0]   cand;
   logic                   accept, commit;

   assign a_msb = alu_a[DATA_W-1];
   assign b_msb = alu_b[DATA_W-1];
   assign r_msb = alu_result[DATA_W-1];

   // A logic op keeps C/V from the newest flags, which may still be pending.
   assign cur_c = (state_q == PENDING) ? pend_q[C_BIT] : cond_q[C_BIT];
   assign cur_v = (state_q == PENDING) ? pend_q[V_BIT] : cond_q[V_BIT];

   assign accept = alu_valid & alu_set_flags & ~stall & ~flush & ~restore
                   & (alu_op_class != CLS_RSVD);
   assign commit = (state_q == PENDING) & ~stall & ~flush & ~restore;

   // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
   always_comb begin
      cand_c = cur_c;
      cand_v = cur_v;
      unique case (alu_op_class)
         CLS_ADD: begin
            cand_c = alu_carry_out;
            cand_v = (a_msb == b_msb) & (r_msb != a_msb);
         end
         CLS_SUB: begin
            cand_c = alu_carry_out;
            cand_v = (a_msb != b_msb) & (r_msb != a_msb);
         end
         CLS_LOGIC, CLS_RSVD: ;
      endcase
      cand        = '0;
      cand[N_BIT] = r_msb;
      cand[V_BIT] = cand_v;
      cand[C_BIT] = cand_c;
      cand[Z_BIT] = (alu_result == '0);
   end

   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q;
      cond_d   = cond_q;
      shadow_d = shadow_q;
      if (restore) begin
         cond_d  = shadow_q;
         state_d = EMPTY;
      end else begin
         if (save) shadow_d = cond_q;
         if (flush) begin
            state_d = EMPTY;
         end else begin
            if (commit) begin
               cond_d  = pend_q;
               state_d = EMPTY;
            end
            // A same-edge accept overrides the commit's EMPTY.
            if (accept) begin
               pend_d  = cand;
               state_d = PENDING;
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= EMPTY;
         pend_q   <= '0;
         cond_q   <= '0;
         shadow_q <= '0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         cond_q   <= cond_d;
         shadow_q <= shadow_d;
      end
   end

   assign cond_code  = cond_q;
   assign flags_busy = (state_q == PENDING);

endmodule

// File: tb/tb_cond_flags_reg.sv
// Self-checking bench for cond_flags_reg: directed scenarios plus randomized
// traffic compared against a queue-based flag model.
module tb_cond_flags_reg;

   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              alu_valid, alu_set_flags, alu_carry_out;
   logic [1:0]        alu_op_class;
   logic [DATA_W-1:0] alu_a, alu_b, alu_result;
   logic              stall, flush, save, restore;
   logic [3:0]        cond_code;
   logic              flags_busy;

   int errors = 0;
   int checks = 0;

   // Model: architectural flags, shadow, and a pending queue of depth <= 1.
   logic [3:0] m_arch;
   logic [3:0] m_shadow;
   logic [3:0] m_pend[$];

   cond_flags_reg #(.DATA_W(DATA_W), .COND_BITS(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_set_flags(alu_set_flags),
      .alu_op_class(alu_op_class),
      .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
      .alu_carry_out(alu_carry_out),
      .stall(stall), .flush(flush), .save(save), .restore(restore),
      .cond_code(cond_code), .flags_busy(flags_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Flags from the arithmetic meaning of the operation (operands are consistent).
   function automatic logic [3:0] model_flags(input logic [1:0] cls, input logic [31:0] a, b, r,
                                              input logic co, input logic [3:0] newest);
      longint sa, sb, sr;
      logic n, z, c, v;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sr = longint'($signed(r));
      n = r[31];
      z = (r == 32'd0);
      c = newest[1];
      v = newest[2];
      if (cls == 2'b01) begin c = co; v = (sa + sb) != sr; end
      if (cls == 2'b10) begin c = co; v = (sa - sb) != sr; end
      return {n, v, c, z};
   endfunction

   task automatic model_edge();
      logic [3:0] newest, cand;
      bit acc;
      newest = (m_pend.size() != 0) ? m_pend[0] : m_arch;
      cand   = model_flags(alu_op_class, alu_a, alu_b, alu_result, alu_carry_out, newest);
      acc    = alu_valid && alu_set_flags && !stall && alu_op_class != 2'b11;
      if (restore) begin
         m_arch = m_shadow;
         m_pend.delete();
      end else begin
         if (save) m_shadow = m_arch;
         if (flush) m_pend.delete();
         else begin
            if (m_pend.size() != 0 && !stall) m_arch = m_pend.pop_front();
            if (acc) begin m_pend.delete(); m_pend.push_back(cand); end
         end
      end
   endtask

   task automatic drive(input logic v, s, input logic [1:0] cls,
                        input logic [31:0] a, b, r, input logic co,
                        input logic st, fl, sv, rs);
      alu_valid = v; alu_set_flags = s; alu_op_class = cls;
      alu_a = a; alu_b = b; alu_result = r; alu_carry_out = co;
      stall = st; flush = fl; save = sv; restore = rs;
   endtask

   // One clock: model and DUT see the same inputs; outputs checked #1 after the edge.
   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check({tag, ".cond"}, 32'(cond_code), 32'(m_arch));
      check({tag, ".busy"}, 32'(flags_busy), 32'(m_pend.size() != 0));
   endtask

   task automatic idle();          drive(0,0,2'b00,0,0,0,0, 0,0,0,0); endtask
   task automatic op_sub55();      drive(1,1,2'b10,5,5,0,1, 0,0,0,0); endtask
   task automatic op_add_ovf();    drive(1,1,2'b01,32'h7FFF_FFFF,1,32'h8000_0000,0, 0,0,0,0); endtask
   task automatic op_logic_zero(); drive(1,1,2'b00,0,0,0,0, 0,0,0,0); endtask

   task automatic rand_op();
      logic [1:0]  cls;
      logic [31:0] a, b, r;
      logic        co;
      logic [32:0] wide;
      cls = 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h7FFF_FFFF;
      if ($urandom_range(0, 5) == 0) b = 32'h8000_0000;
      co = 1'b0;
      case (cls)
         2'b00: begin
            case ($urandom_range(0, 2))
               0: r = a & b;
               1: r = a | b;
               default: r = a ^ b;
            endcase
            co = 1'($urandom_range(0, 1));
         end
         2'b01: begin wide = {1'b0, a} + {1'b0, b}; r = wide[31:0]; co = wide[32]; end
         2'b10: begin wide = {1'b0, a} + {1'b0, ~b} + 33'd1; r = wide[31:0]; co = wide[32]; end
         default: begin r = $urandom; co = 1'($urandom_range(0, 1)); end
      endcase
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8, cls, a, b, r, co,
            $urandom_range(0, 9) < 2, $urandom_range(0, 99) < 8,
            $urandom_range(0, 9) < 1, $urandom_range(0, 99) < 5);
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      m_arch = 4'b0000; m_shadow = 4'b0000; m_pend.delete();
      #12;
      check("reset.cond", 32'(cond_code), 32'h0);
      check("reset.busy", 32'(flags_busy), 32'h0);
      rst_n = 1'b1;

      // Subtract 5-5: busy after first edge, 0011 after second.
      op_sub55();   step("sub.acc");
      check("sub.busy1", 32'(flags_busy), 32'h1);
      idle();       step("sub.commit");
      check("sub.cond", 32'(cond_code), 32'h3);

      // Signed add overflow.
      op_add_ovf(); step("add.acc");
      idle();       step("add.commit");
      check("add.cond", 32'(cond_code), 32'hC);

      // Accept, stall three cycles, then flush.
      op_sub55();   step("sf.acc");
      for (int i = 0; i < 3; i++) begin
         drive(1,1,2'b10,5,5,0,1, 1,0,0,0); step("sf.stall");
         check("sf.stall.cond", 32'(cond_code), 32'hC);
         check("sf.stall.busy", 32'(flags_busy), 32'h1);
      end
      drive(1,1,2'b01,1,1,2,0, 0,1,0,0); step("sf.flush");
      check("sf.flush.cond", 32'(cond_code), 32'hC);
      check("sf.flush.busy", 32'(flags_busy), 32'h0);

      // Save 0011, move to 1100, restore while an update is pending.
      op_sub55();   step("sr.acc");
      idle();       step("sr.commit");
      drive(0,0,2'b00,0,0,0,0, 0,0,1,0); step("sr.save");
      op_add_ovf(); step("sr.acc2");
      idle();       step("sr.commit2");
      check("sr.upd.cond", 32'(cond_code), 32'hC);
      op_sub55();   step("sr.pend");
      drive(1,1,2'b01,1,1,2,0, 0,0,0,1); step("sr.restore");
      check("sr.restore.cond", 32'(cond_code), 32'h3);
      check("sr.restore.busy", 32'(flags_busy), 32'h0);

      // Back-to-back subtract then logic, starting from 1100.
      op_add_ovf();    step("bb.pre");
      idle();          step("bb.pre2");
      op_sub55();      step("bb.sub");
      check("bb.sub.busy", 32'(flags_busy), 32'h1);
      op_logic_zero(); step("bb.logic");
      check("bb.logic.cond", 32'(cond_code), 32'h3);
      check("bb.logic.busy", 32'(flags_busy), 32'h1);
      idle();          step("bb.done");
      check("bb.done.cond", 32'(cond_code), 32'h3);

      // Class 11 never updates.
      drive(1,1,2'b11,0,0,32'h8000_0000,1, 0,0,0,0); step("rsvd");
      check("rsvd.busy", 32'(flags_busy), 32'h0);

      // Reset asserted mid-PENDING clears immediately; accept on first edge after.
      op_add_ovf(); step("rst.acc");
      rst_n = 1'b0;
      #1;
      m_arch = 4'b0000; m_shadow = 4'b0000; m_pend.delete();
      check("rst.mid.cond", 32'(cond_code), 32'h0);
      check("rst.mid.busy", 32'(flags_busy), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      op_add_ovf(); step("rst.first");
      check("rst.first.busy", 32'(flags_busy), 32'h1);
      idle();       step("rst.first2");
      check("rst.first.cond", 32'(cond_code), 32'hC);

      for (int i = 0; i < 3000; i++) begin
         rand_op();
         step("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
